// File: rtl/dac_sample_scheduler.sv
// Round-robin sample scheduler for the serial DAC shifter.
// Holds one captured sample per channel and sequences load/cs for each frame.
module dac_sample_scheduler #(
  parameter int NUM_CH       = 4,
  parameter int DATA_W       = 12,
  parameter int SHIFT_CYCLES = 64,
  parameter int GAP_CYCLES   = 4,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic                     dac_load,
  output logic                     dac_cs,
  output logic [DATA_W-1:0]        dac_data,
  output logic [CH_W-1:0]          cur_ch,
  output logic                     busy
);

  localparam int MAX_CYC = (SHIFT_CYCLES > GAP_CYCLES) ? SHIFT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [NUM_CH-1:0] valid_q, valid_d;
  logic [DATA_W-1:0] hold_q [NUM_CH];
  logic [DATA_W-1:0] hold_d [NUM_CH];
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic              load_q, load_d;
  logic              cs_q, cs_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CH_W-1:0]   cur_ch_q, cur_ch_d;

  logic              found;
  logic [CH_W-1:0]   grant_sel;
  logic [CH_W-1:0]   cand;

  // Scanning backwards from the farthest offset lets the nearest valid channel win.
  always_comb begin
    found     = 1'b0;
    grant_sel = '0;
    cand      = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = CH_W'((int'(ptr_q) + i) % NUM_CH);
      if (valid_q[cand]) begin
        found     = 1'b1;
        grant_sel = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    valid_d  = valid_q;
    hold_d   = hold_q;
    ack_d    = '0;
    data_d   = data_q;
    cur_ch_d = cur_ch_q;

    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_req[k] && !valid_q[k]) begin
        valid_d[k] = 1'b1;
        hold_d[k]  = ch_data[k*DATA_W +: DATA_W];
        ack_d[k]   = 1'b1;
      end
    end

    // Data is presented during the load strobe; the granted slot frees once LOAD ends.
    case (state_q)
      IDLE: begin
        if (enable && found) begin
          state_d  = LOAD;
          grant_d  = grant_sel;
          data_d   = hold_q[grant_sel];
          cur_ch_d = grant_sel;
        end
      end
      LOAD: begin
        state_d          = SHIFT;
        cnt_d            = CNT_W'(SHIFT_CYCLES - 1);
        valid_d[grant_q] = 1'b0;
        ptr_d            = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    load_d = (state_d == LOAD);
    cs_d   = (state_d != SHIFT);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      grant_q  <= '0;
      valid_q  <= '0;
      ack_q    <= '0;
      load_q   <= 1'b0;
      cs_q     <= 1'b1;
      busy_q   <= 1'b0;
      data_q   <= '0;
      cur_ch_q <= '0;
      for (int k = 0; k < NUM_CH; k++) hold_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      valid_q  <= valid_d;
      ack_q    <= ack_d;
      load_q   <= load_d;
      cs_q     <= cs_d;
      busy_q   <= busy_d;
      data_q   <= data_d;
      cur_ch_q <= cur_ch_d;
      for (int k = 0; k < NUM_CH; k++) hold_q[k] <= hold_d[k];
    end
  end

  assign ch_ack   = ack_q;
  assign dac_load = load_q;
  assign dac_cs   = cs_q;
  assign dac_data = data_q;
  assign cur_ch   = cur_ch_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Bench for dac_sample_scheduler: frame-timeline reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dac_sample_scheduler;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 12;
  localparam int SHIFT  = 64;
  localparam int GAP    = 4;
  localparam int CH_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     enable;
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_ack;
  logic                     dac_load;
  logic                     dac_cs;
  logic [DATA_W-1:0]        dac_data;
  logic [CH_W-1:0]          cur_ch;
  logic                     busy;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  logic [NUM_CH-1:0] refill_mask = '0;

  dac_sample_scheduler #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SHIFT_CYCLES(SHIFT), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_req(ch_req), .ch_data(ch_data),
    .ch_ack(ch_ack), .dac_load(dac_load), .dac_cs(dac_cs), .dac_data(dac_data),
    .cur_ch(cur_ch), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is a timeline measured from its load cycle (phase 0).
  // Phases 1..SHIFT have cs low, the frame is busy through phase SHIFT+GAP,
  // and a new grant can only be made from a non-busy cycle.
  int                m_valid [NUM_CH];
  logic [DATA_W-1:0] m_hold  [NUM_CH];
  int                m_ptr, m_grant, m_phase;
  bit                m_in_frame;
  bit                model_ready = 1'b0;
  logic [NUM_CH-1:0] exp_ack;
  logic [DATA_W-1:0] exp_data;
  int                exp_cur;

  always @(posedge clk) begin : model
    int old_valid [NUM_CH];
    int g;
    bit any;
    cycle++;
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        m_valid[k] = 0;
        m_hold[k]  = '0;
      end
      m_ptr = 0; m_grant = 0; m_phase = 0; m_in_frame = 1'b0;
      exp_ack = '0; exp_data = '0; exp_cur = 0;
      model_ready = 1'b1;
    end else begin
      any = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        old_valid[k] = m_valid[k];
        if (m_valid[k] != 0) any = 1'b1;
      end
      exp_ack = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_req[k] && old_valid[k] == 0) begin
          exp_ack[k] = 1'b1;
          m_valid[k] = 1;
          m_hold[k]  = ch_data[k*DATA_W +: DATA_W];
        end
      end
      if (m_in_frame) begin
        m_phase++;
        if (m_phase == 1) begin
          m_valid[m_grant] = 0;
          m_ptr = (m_grant + 1) % NUM_CH;
        end
        if (m_phase > SHIFT + GAP) m_in_frame = 1'b0;
      end else if (enable && any) begin
        g = m_ptr;
        for (int i = 0; i < NUM_CH; i++) begin
          if (old_valid[(m_ptr + i) % NUM_CH] != 0) begin
            g = (m_ptr + i) % NUM_CH;
            break;
          end
        end
        m_grant    = g;
        m_in_frame = 1'b1;
        m_phase    = 0;
        exp_data   = m_hold[g];
        exp_cur    = g;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  always @(negedge clk) begin
    if (model_ready) begin
      checkOutput("ch_ack",   32'(ch_ack),   32'(exp_ack));
      checkOutput("dac_load", 32'(dac_load), 32'(m_in_frame && m_phase == 0));
      checkOutput("dac_cs",   32'(dac_cs),   32'(!(m_in_frame && m_phase >= 1 && m_phase <= SHIFT)));
      checkOutput("busy",     32'(busy),     32'(m_in_frame));
      checkOutput("dac_data", 32'(dac_data), 32'(exp_data));
      checkOutput("cur_ch",   32'(cur_ch),   32'(exp_cur));
    end
  end

  task automatic applyStimulus(input int k, input logic [DATA_W-1:0] data);
    ch_data[k*DATA_W +: DATA_W] = data;
    ch_req[k] = 1'b1;
  endtask

  // Requesters drop on ack; channels in refill_mask re-request right away.
  task automatic service();
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_req[k] && ch_ack[k]) ch_req[k] = 1'b0;
      else if (refill_mask[k])    ch_req[k] = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    service();
  endtask

  task automatic waitLoad(input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (dac_load) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    checkOutput(name, 32'(ok), 32'd1);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt, lat, loads, prev, rst_hold;
    bit ok;
    rst = 1'b1; enable = 1'b0; ch_req = '0; ch_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset mid-SHIFT
    enable = 1'b1;
    applyStimulus(0, 12'h123);
    waitLoad(20, "t1_load_wait");
    repeat (10) step();
    checkOutput("t1_in_shift", 32'(dac_cs), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t1_rst_cs",   32'(dac_cs),   32'd1);
    checkOutput("t1_rst_load", 32'(dac_load), 32'd0);
    checkOutput("t1_rst_busy", 32'(busy),     32'd0);
    checkOutput("t1_rst_ack",  32'(ch_ack),   32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single sample on channel 2
    applyStimulus(2, 12'hA5C);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ch_ack[2]) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("t2_ack_seen", 32'(ok), 32'd1);
    ch_req[2] = 1'b0;
    @(negedge clk);
    checkOutput("t2_ack_once", 32'(ch_ack[2]), 32'd0);
    waitLoad(10, "t2_load_wait");
    checkOutput("t2_cur_ch", 32'(cur_ch), 32'd2);
    checkOutput("t2_data", 32'(dac_data), 32'hA5C);
    step();
    checkOutput("t2_load_pulse", 32'(dac_load), 32'd0);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (dac_cs) break;
      cnt++;
      step();
    end
    checkOutput("t2_cs_low_cycles", 32'(cnt), 32'd64);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!(busy && dac_cs)) break;
      cnt++;
      step();
    end
    checkOutput("t2_gap_cycles", 32'(cnt), 32'd4);

    // Round-robin over all four channels from pointer 0
    enable = 1'b0;
    pulseReset();
    for (int k = 0; k < NUM_CH; k++) applyStimulus(k, DATA_W'(12'h111 * (k + 1)));
    repeat (3) step();
    enable = 1'b1;
    prev = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      waitLoad(200, "t3_load_wait");
      checkOutput("t3_order", 32'(cur_ch), 32'(i));
      checkOutput("t3_data", 32'(dac_data), 32'(12'h111 * (i + 1)));
      if (i > 0) checkOutput("t3_spacing", 32'(cycle - prev), 32'd70);
      prev = cycle;
      step();
    end

    // Fairness: ch1 always re-requests, ch3 requests once
    enable = 1'b0;
    pulseReset();
    applyStimulus(1, 12'hB01);
    applyStimulus(3, 12'hD03);
    refill_mask = 4'b0010;
    repeat (3) step();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      waitLoad(200, "t4_load_wait");
      checkOutput("t4_order", 32'(cur_ch), (i == 1) ? 32'd3 : 32'd1);
      step();
    end
    refill_mask = '0;
    ch_req = '0;

    // Enable dropped mid-frame with ch0 pending
    enable = 1'b0;
    pulseReset();
    applyStimulus(2, 12'h222);
    repeat (2) step();
    enable = 1'b1;
    waitLoad(20, "t5_load_wait");
    repeat (10) step();
    enable = 1'b0;
    applyStimulus(0, 12'h0C0);
    loads = 0;
    for (int i = 0; i < 120; i++) begin
      step();
      if (dac_load) loads++;
    end
    checkOutput("t5_no_load_disabled", 32'(loads), 32'd0);
    checkOutput("t5_idle_after_frame", 32'(busy), 32'd0);
    enable = 1'b1;
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      lat++;
      if (dac_load) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("t5_load_after_enable", 32'(ok), 32'd1);
    checkOutput("t5_latency_le2", 32'(lat <= 2), 32'd1);
    checkOutput("t5_cur_ch", 32'(cur_ch), 32'd0);

    // Request arriving in GAP is acked at once and loads from the first IDLE
    step();
    for (int i = 0; i < 200; i++) begin
      step();
      if (dac_cs) break;
    end
    applyStimulus(0, 12'h6A6);
    @(negedge clk);
    checkOutput("t6_ack_immediate", 32'(ch_ack[0]), 32'd1);
    ch_req[0] = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      if (dac_load) break;
      step();
      lat++;
    end
    checkOutput("t6_load_latency", 32'(lat), 32'd4);
    checkOutput("t6_cur_ch", 32'(cur_ch), 32'd0);
    checkOutput("t6_data", 32'(dac_data), 32'h6A6);

    // Randomized traffic, enable toggling and occasional resets
    rst_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b0;
      end else if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        rst_hold = $urandom_range(1, 3);
      end
      enable = ($urandom_range(0, 9) != 0);
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_req[k] && ch_ack[k]) begin
          ch_req[k] = 1'b0;
        end else if (!ch_req[k] && $urandom_range(0, 15) == 0) begin
          ch_data[k*DATA_W +: DATA_W] = DATA_W'($urandom);
          ch_req[k] = 1'b1;
        end
      end
    end
    rst = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
